// File: rtl/dbg_pkg.sv
// Shared debug-port definitions: controller FSM states and memory access size
// encodings, plus the read-data zero-extension used on memory reads.
package dbg_pkg;

  typedef enum logic [2:0] {
    RUN,
    PAUSING,
    PAUSED,
    REG,
    MEM_WAIT,
    MEM_WR
  } dbg_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic [31:0] size_ext(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: size_ext = {24'b0, d[7:0]};
      SZ_HALF: size_ext = {16'b0, d[15:0]};
      SZ_WORD: size_ext = d;
      default: size_ext = d;
    endcase
  endfunction

endpackage

// File: rtl/mcu_dbg_port.sv
// Debug port bridging serial-side command strobes onto the MCU: pause/resume/reset
// control of the core and register-file / memory accesses while paused.
module mcu_dbg_port
  import dbg_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pause,
  input  logic        resume,
  input  logic        reset,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        out_valid,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic        instr_done,
  input  logic [31:0] rf_rdata,
  input  logic [31:0] mem_rdata,
  output logic        mcu_busy,
  output logic [31:0] d_rd,
  output logic        mcu_stall,
  output logic        mcu_rst,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size_o,
  output logic        mem_re,
  output logic        mem_we
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

  dbg_state_e state;
  logic [2:0] lat_cnt;

  // Busy must already be high in the strobe cycle itself.
  assign mcu_busy = out_valid | ~((state == RUN) | (state == PAUSED));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      lat_cnt    <= '0;
      d_rd       <= '0;
      mcu_stall  <= 1'b0;
      mcu_rst    <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      rf_we      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_size_o <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      mcu_rst <= 1'b0;
      rf_we   <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        RUN, PAUSED: begin
          if (out_valid) begin
            if (reset) begin
              mcu_rst   <= 1'b1;
              mcu_stall <= 1'b0;
              state     <= RUN;
            end else if (pause) begin
              // An instruction retiring in the strobe cycle completes the pause at once.
              if (state == RUN) begin
                if (instr_done) begin
                  mcu_stall <= 1'b1;
                  state     <= PAUSED;
                end else begin
                  state <= PAUSING;
                end
              end
            end else if (resume) begin
              if (state == PAUSED) begin
                mcu_stall <= 1'b0;
                state     <= RUN;
              end
            end else if (state == PAUSED) begin
              if (mem_rd || mem_wr) begin
                mem_addr   <= addr;
                mem_wdata  <= d_in;
                mem_size_o <= mem_size;
                lat_cnt    <= '0;
                mem_re     <= mem_rd;
                mem_we     <= ~mem_rd;
                state      <= mem_rd ? MEM_WAIT : MEM_WR;
              end else if (reg_rd) begin
                rf_addr <= addr[4:0];
                state   <= REG;
              end else if (reg_wr) begin
                rf_addr  <= addr[4:0];
                rf_wdata <= d_in;
                rf_we    <= |addr[4:0];
              end
            end
          end
        end
        PAUSING: begin
          if (instr_done) begin
            mcu_stall <= 1'b1;
            state     <= PAUSED;
          end
        end
        REG: begin
          d_rd  <= rf_rdata;
          state <= PAUSED;
        end
        MEM_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            d_rd  <= size_ext(mem_size_o, mem_rdata);
            state <= PAUSED;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        MEM_WR:  state <= PAUSED;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_dbg_port.sv
// Bench for mcu_dbg_port: directed vector table, random commands against a
// transaction-level model, and a reset-during-memory-read sequence.
module tb_mcu_dbg_port;

  localparam int MEM_LAT = 2;
  localparam logic [6:0] C_RST = 7'h40, C_PAU = 7'h20, C_RES = 7'h10, C_MRD = 7'h08,
                         C_MWR = 7'h04, C_RRD = 7'h02, C_RWR = 7'h01;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pause = 0, resume = 0, reset = 0, reg_rd = 0, reg_wr = 0, mem_rd = 0, mem_wr = 0;
  logic [1:0]  mem_size = '0;
  logic        out_valid = 0, instr_done = 0;
  logic [31:0] addr = '0, d_in = '0, rf_rdata = '0, mem_rdata = '0;
  logic        mcu_busy, mcu_stall, mcu_rst, rf_we, mem_re, mem_we;
  logic [31:0] d_rd, rf_wdata, mem_addr, mem_wdata;
  logic [4:0]  rf_addr;
  logic [1:0]  mem_size_o;

  mcu_dbg_port #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .resume(resume), .reset(reset),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_size(mem_size), .out_valid(out_valid), .addr(addr), .d_in(d_in),
    .instr_done(instr_done), .rf_rdata(rf_rdata), .mem_rdata(mem_rdata),
    .mcu_busy(mcu_busy), .d_rd(d_rd), .mcu_stall(mcu_stall), .mcu_rst(mcu_rst),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size_o(mem_size_o), .mem_re(mem_re), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pre_paused;
    logic [6:0]  cmd;
    logic [31:0] a, d;
    logic [1:0]  sz;
    logic [31:0] mrd, rfd;
    int          idle_k;
    int          busy;
    logic [31:0] drd;
    int          n_re, n_we, n_rfwe, n_rst;
    logic        stall;
    logic        rd_reg;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int n_re = 0, n_we = 0, n_rfwe = 0, n_rst = 0;
  logic [31:0] re_addr, we_addr, we_data, rfwe_data, mem_word = '0;
  logic [1:0]  re_size;
  logic [4:0]  rfwe_addr;
  int          mk = 255;

  // Pulse monitor plus memory responder: data valid exactly MEM_LAT cycles after mem_re.
  always @(negedge clk) begin
    if (mem_re) begin n_re++; re_addr = mem_addr; re_size = mem_size_o; end
    if (mem_we) begin n_we++; we_addr = mem_addr; we_data = mem_wdata; end
    if (rf_we) begin n_rfwe++; rfwe_addr = rf_addr; rfwe_data = rf_wdata; end
    if (mcu_rst) n_rst++;
    if (mem_re) mk = 0;
    else if (mk < 255) mk++;
    mem_rdata = (mk == MEM_LAT) ? mem_word : (mem_word ^ 32'hA5A5_5A5A);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_cmd(input logic [6:0] c);
    {reset, pause, resume, mem_rd, mem_wr, reg_rd, reg_wr} = c;
  endtask

  function automatic vec_t mk_vec(input logic pre, input logic [6:0] cmd, input logic [31:0] a, d,
      input logic [1:0] sz, input logic [31:0] mrd, rfd, input int k, input int busy,
      input logic [31:0] drd, input int re, we, rfwe, rst, input logic stall, input logic rdreg);
    vec_t v;
    v.pre_paused = pre; v.cmd = cmd; v.a = a; v.d = d; v.sz = sz; v.mrd = mrd; v.rfd = rfd;
    v.idle_k = k; v.busy = busy; v.drd = drd; v.n_re = re; v.n_we = we; v.n_rfwe = rfwe;
    v.n_rst = rst; v.stall = stall; v.rd_reg = rdreg;
    return v;
  endfunction

  // Transaction-level reference: outcome of one accepted strobe from the current mode.
  function automatic vec_t model(input vec_t v, input logic paused, input logic [31:0] drd);
    vec_t e = v;
    e.busy = 1; e.drd = drd; e.n_re = 0; e.n_we = 0; e.n_rfwe = 0; e.n_rst = 0;
    e.stall = paused; e.rd_reg = 0;
    if (v.cmd[6]) begin
      e.n_rst = 1; e.stall = 0;
    end else if (v.cmd[5]) begin
      if (!paused) begin e.busy = v.idle_k + 1; e.stall = 1; end
    end else if (v.cmd[4]) begin
      e.stall = 0;
    end else if (paused) begin
      if (v.cmd[3]) begin
        e.busy = MEM_LAT + 2; e.n_re = 1;
        e.drd = (v.sz == 0) ? (v.mrd % 256) : (v.sz == 1) ? (v.mrd % 65536) : v.mrd;
      end else if (v.cmd[2]) begin
        e.busy = 2; e.n_we = 1;
      end else if (v.cmd[1]) begin
        e.busy = 2; e.drd = v.rfd; e.rd_reg = 1;
      end else if (v.cmd[0]) begin
        e.n_rfwe = (v.a % 32 != 0) ? 1 : 0;
      end
    end
    return e;
  endfunction

  task automatic hard_reset();
    @(posedge clk); #1;
    rst_n = 0; set_cmd('0); out_valid = 0; instr_done = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic strobe(input vec_t v, output int busy);
    bit done = 0;
    busy = 0;
    @(posedge clk); #1;
    mem_word = v.mrd; rf_rdata = v.rfd;
    set_cmd(v.cmd); addr = v.a; d_in = v.d; mem_size = v.sz;
    out_valid = 1; instr_done = (v.idle_k == 0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!mcu_busy) begin done = 1; break; end
      busy++;
      @(posedge clk); #1;
      set_cmd('0); out_valid = 0; instr_done = (c + 1 >= v.idle_k);
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL busy_timeout: busy still high after 40 cycles");
    end
    instr_done = 0;
    @(negedge clk);
  endtask

  task automatic go_paused();
    int b;
    strobe(mk_vec(0, C_PAU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), b);
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    int busy, b_re, b_we, b_rfwe, b_rst;
    b_re = n_re; b_we = n_we; b_rfwe = n_rfwe; b_rst = n_rst;
    strobe(v, busy);
    check({nm, " busy"}, 32'(busy), 32'(v.busy));
    check({nm, " d_rd"}, d_rd, v.drd);
    check({nm, " stall"}, 32'(mcu_stall), 32'(v.stall));
    check({nm, " mem_re"}, 32'(n_re - b_re), 32'(v.n_re));
    check({nm, " mem_we"}, 32'(n_we - b_we), 32'(v.n_we));
    check({nm, " rf_we"}, 32'(n_rfwe - b_rfwe), 32'(v.n_rfwe));
    check({nm, " mcu_rst"}, 32'(n_rst - b_rst), 32'(v.n_rst));
    if (v.n_re > 0) begin
      check({nm, " rd_addr"}, re_addr, v.a);
      check({nm, " rd_size"}, 32'(re_size), 32'(v.sz));
    end
    if (v.n_we > 0) begin
      check({nm, " wr_addr"}, we_addr, v.a);
      check({nm, " wr_data"}, we_data, v.d);
    end
    if (v.n_rfwe > 0) begin
      check({nm, " rf_waddr"}, 32'(rfwe_addr), 32'(v.a[4:0]));
      check({nm, " rf_wdata"}, rfwe_data, v.d);
    end
    if (v.rd_reg) check({nm, " rf_addr"}, 32'(rf_addr), 32'(v.a[4:0]));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[18];
    vec_t v;
    logic        paused;
    logic [31:0] drd;

    //           pre cmd          a            d             sz mrd           rfd          k  busy drd           re we wf rs st rr
    tv[0]  = mk_vec(0, C_PAU,       0,           0,            0, 0,            0,           4, 5, 0,            0, 0, 0, 0, 1, 0);
    tv[1]  = mk_vec(1, C_RRD,       5,           0,            0, 0,            32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1);
    tv[2]  = mk_vec(1, C_MRD,       32'h100,     0,            0, 32'h12345678, 0,           0, 4, 32'h78,       1, 0, 0, 0, 1, 0);
    tv[3]  = mk_vec(1, C_MRD,       32'h102,     0,            1, 32'h12345678, 0,           0, 4, 32'h5678,     1, 0, 0, 0, 1, 0);
    tv[4]  = mk_vec(1, C_MRD,       32'h104,     0,            2, 32'h12345678, 0,           0, 4, 32'h12345678, 1, 0, 0, 0, 1, 0);
    tv[5]  = mk_vec(1, C_RWR,       0,           32'hFFFFFFFF, 0, 0,            0,           0, 1, 0,            0, 0, 0, 0, 1, 0);
    tv[6]  = mk_vec(1, C_RWR,       3,           32'hCAFEF00D, 0, 0,            0,           0, 1, 0,            0, 0, 1, 0, 1, 0);
    tv[7]  = mk_vec(0, C_RWR,       3,           32'hCAFEF00D, 0, 0,            0,           0, 1, 0,            0, 0, 0, 0, 0, 0);
    tv[8]  = mk_vec(0, C_MRD,       32'h100,     0,            2, 32'h12345678, 0,           0, 1, 0,            0, 0, 0, 0, 0, 0);
    tv[9]  = mk_vec(1, C_RST|C_PAU, 0,           0,            0, 0,            0,           0, 1, 0,            0, 0, 0, 1, 0, 0);
    tv[10] = mk_vec(1, C_MWR,       32'h200,     32'h55AA,     2, 0,            0,           0, 2, 0,            0, 1, 0, 0, 1, 0);
    tv[11] = mk_vec(1, C_RES,       0,           0,            0, 0,            0,           0, 1, 0,            0, 0, 0, 0, 0, 0);
    tv[12] = mk_vec(0, C_PAU,       0,           0,            0, 0,            0,           0, 1, 0,            0, 0, 0, 0, 1, 0);
    tv[13] = mk_vec(1, C_PAU|C_MRD, 32'h100,     0,            2, 32'h1234,     0,           0, 1, 0,            0, 0, 0, 0, 1, 0);
    tv[14] = mk_vec(0, C_RES,       0,           0,            0, 0,            0,           0, 1, 0,            0, 0, 0, 0, 0, 0);
    tv[15] = mk_vec(1, C_MRD|C_RRD, 32'h104,     0,            2, 32'hA1B2C3D4, 32'h11,      0, 4, 32'hA1B2C3D4, 1, 0, 0, 0, 1, 0);
    tv[16] = mk_vec(0, C_RST,       0,           0,            0, 0,            0,           0, 1, 0,            0, 0, 0, 1, 0, 0);
    tv[17] = mk_vec(1, C_RRD|C_RWR, 7,           32'h99,       0, 0,            32'h77,      0, 2, 32'h77,       0, 0, 0, 0, 1, 1);

    // Reset state, then busy follows out_valid combinationally.
    hard_reset();
    @(negedge clk);
    check("rst d_rd", d_rd, 0);
    check("rst stall", 32'(mcu_stall), 0);
    check("rst mcu_rst", 32'(mcu_rst), 0);
    check("rst strobes", 32'({rf_we, mem_re, mem_we}), 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst rf_wdata", rf_wdata, 0);
    check("rst rf_addr/size", 32'({rf_addr, mem_size_o}), 0);
    check("rst busy", 32'(mcu_busy), 0);
    #1 out_valid = 1;
    #1 check("busy on strobe", 32'(mcu_busy), 1);
    out_valid = 0;

    foreach (tv[i]) begin
      hard_reset();
      if (tv[i].pre_paused) go_paused();
      apply_vec(tv[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while a memory read is waiting on data.
    hard_reset();
    go_paused();
    apply_vec(mk_vec(1, C_RRD, 9, 0, 0, 0, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1), "abort_pre");
    @(posedge clk); #1;
    mem_word = 32'h12345678; set_cmd(C_MRD); addr = 32'h300; mem_size = 2; out_valid = 1;
    @(posedge clk); #1;
    set_cmd('0); out_valid = 0; rst_n = 0;
    @(negedge clk);
    check("abort mem_re pulse", 32'(mem_re), 1);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("abort mem_re", 32'(mem_re), 0);
    check("abort d_rd", d_rd, 0);
    check("abort busy", 32'(mcu_busy), 0);
    check("abort stall", 32'(mcu_stall), 0);
    check("abort mem_addr", mem_addr, 0);
    repeat (6) @(negedge clk);
    check("abort late rdata", d_rd, 0);
    check("abort late busy", 32'(mcu_busy), 0);

    // Random command stream against the transaction model.
    hard_reset();
    paused = 0; drd = 0;
    for (int i = 0; i < 200; i++) begin
      v.pre_paused = paused;
      v.cmd = {($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0)};
      v.a = $urandom;
      if ($urandom_range(0, 3) == 0) v.a = v.a & 32'hFFFF_FFE0;
      v.d = $urandom; v.sz = 2'($urandom_range(0, 2));
      v.mrd = $urandom; v.rfd = $urandom; v.idle_k = $urandom_range(0, 5);
      v = model(v, paused, drd);
      apply_vec(v, $sformatf("rnd%0d", i));
      paused = v.stall; drd = v.drd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_dbg_port.md
MCU_DBG_PORT -- requirements
Module: mcu_dbg_port

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: cycles from mem_re assertion to mem_rdata valid, legal range 1-7.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports pause, resume, reset, reg_rd, reg_wr, mem_rd and mem_wr, input, 1 bit each: command levels from the debug controller.
REQ-005 SHALL have port mem_size, input, 2 bits: access size, 0=byte, 1=half, 2=word.
REQ-006 SHALL have port out_valid, input, 1 bit: one-cycle strobe qualifying the command levels.
REQ-007 SHALL have ports addr and d_in, input, 32 bits each: access address (register index in addr[4:0]) and write data.
REQ-008 SHALL have port instr_done, input, 1 bit: MCU retires an instruction this cycle.
REQ-009 SHALL have ports rf_rdata and mem_rdata, input, 32 bits each: register-file and memory read data.
REQ-010 SHALL have port mcu_busy, output, 1 bit: to the controller.
REQ-011 SHALL have port d_rd, output, 32 bits: read data returned to the serial side.
REQ-012 SHALL have ports mcu_stall and mcu_rst, output, 1 bit each: pipeline hold and core reset.
REQ-013 SHALL have ports rf_addr (5 bits), rf_wdata (32 bits) and rf_we (1 bit), output: register-file port.
REQ-014 SHALL have ports mem_addr (32 bits), mem_wdata (32 bits), mem_size_o (2 bits), mem_re (1 bit) and mem_we (1 bit), output: memory port.

Function
REQ-015 SHALL sample command inputs only in a cycle where out_valid=1 and the FSM is RUN or PAUSED; all other out_valid cycles are ignored.
REQ-016 SHALL drive mcu_busy = out_valid OR (state not in {RUN, PAUSED}), combinationally, so busy is visible in the strobe cycle.
REQ-017 SHALL use states RUN, PAUSING, PAUSED, REG, MEM_WAIT and MEM_WR.
REQ-018 SHALL resolve simultaneous command levels by priority reset > pause > resume > mem_rd > mem_wr > reg_rd > reg_wr.
REQ-019 SHALL, on reset: pulse mcu_rst for exactly 1 cycle after the strobe, clear mcu_stall and enter RUN, from any accepting state.
REQ-020 SHALL, on pause in RUN: enter PAUSING; on the first instr_done=1 (including the same cycle as entry), set mcu_stall=1 and enter PAUSED.
REQ-021 SHALL treat pause in PAUSED as a no-op.
REQ-022 SHALL, on resume in PAUSED: clear mcu_stall the next cycle and enter RUN; resume in RUN is a no-op.
REQ-023 SHALL ignore mem and reg commands in RUN: no port activity and d_rd unchanged.
REQ-024 SHALL, on reg_rd in PAUSED: drive rf_addr=addr[4:0], enter REG for 1 cycle, capture d_rd<=rf_rdata and return to PAUSED (busy 2 cycles total).
REQ-025 SHALL, on reg_wr in PAUSED: pulse rf_we for 1 cycle with rf_wdata=d_in; rf_we stays 0 when addr[4:0]=0.
REQ-026 SHALL, on mem_rd: pulse mem_re for 1 cycle, count MEM_LAT cycles in MEM_WAIT, capture and return to PAUSED.
REQ-027 SHALL capture mem_rd data as d_rd<=mem_rdata for size 2, {24'b0,mem_rdata[7:0]} for size 0 and {16'b0,mem_rdata[15:0]} for size 1.
REQ-028 SHALL, on mem_wr: pulse mem_we for 1 cycle in MEM_WR, then return to PAUSED.
REQ-029 SHALL drive mem_addr=addr, mem_wdata=d_in and mem_size_o=mem_size, registered at acceptance and held until return to PAUSED.
REQ-030 SHALL keep mcu_stall=1 throughout REG, MEM_WAIT and MEM_WR.

Reset
REQ-031 SHALL, with rst_n=0 at posedge, force state RUN, d_rd=0, mcu_stall=0, mcu_rst=0, rf_we=0, mem_re=0, mem_we=0, and addr/data outputs 0, aborting any access in progress.
REQ-032 SHALL have mcu_busy=0 after reset unless out_valid=1.

Structure
REQ-033 SHALL take the state enum and the mem_size encodings (BYTE=0, HALF=1, WORD=2) from shared package dbg_pkg.
REQ-034 SHALL have no sub-modules; the latency counter is 3 bits inline.

Verification
REQ-035 Bench SHALL cover: pause strobe with instr_done low for 4 cycles then high -> mcu_busy high 5 cycles, mcu_stall=1 from the next cycle.
REQ-036 Bench SHALL cover: PAUSED, reg_rd addr=5, rf_rdata=0xDEADBEEF -> rf_addr=5, d_rd=0xDEADBEEF, busy exactly 2 cycles.
REQ-037 Bench SHALL cover: PAUSED, mem_rd size 0 addr=0x100, mem_rdata=0x12345678, MEM_LAT=2 -> one mem_re pulse, d_rd=0x00000078, busy 4 cycles.
REQ-038 Bench SHALL cover: reg_wr addr=0 d_in=0xFFFFFFFF -> rf_we never asserted; reg_wr in RUN -> no rf_we, d_rd unchanged.
REQ-039 Bench SHALL cover: strobe with reset+pause both high in PAUSED -> 1-cycle mcu_rst, state RUN, mcu_stall=0.
REQ-040 Bench SHALL cover: rst_n low during MEM_WAIT -> next cycle RUN, mem_re=0, d_rd=0, later mem_rdata ignored.
